idex_elastic_stage: RTL and testbench
=====================================

# idex_elastic_stage

Parametrised ID/EX pipeline stage for the core, replacing the free-running ID/EX latch with an elastic two-entry (main + skid) register. It sits between decode and execute. Decode and execute exchange entries over a valid/ready handshake, so execute can stall without losing an in-flight instruction. A synchronous flush squashes branch/jump shadows, and a saturating counter records execute-side stall cycles.

## Interface
Parameters:
- DATA_W, 32, width of tAdd/tALU/tMux32/tACsl datapath fields
- REG_W, 5, width of register-specifier fields tMux5_1/tMux5_2
- WB_W, 2, width of write-back control bundle
- M_W, 3, width of memory control bundle
- ALUOP_W, 3, width of ALUOp; EX input width is ALUOP_W+2
- CNT_W, 16, width of stall counter

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clkIDEX  in  1  stage clock; all state changes on its rising edge.
  - rstIDEX_n  in  1  asynchronous, active-low reset.
- Decode-side inputs:
  - in_valid  in  1  decode presents an entry.
  - in_ready  out  1  stage can accept an entry this cycle.
  - WB1  in  WB_W  write-back control.
  - M1  in  M_W  memory control.
  - EX  in  ALUOP_W+2  packed execute control: [0]=RegDst, [ALUOP_W:1]=ALUOp, [ALUOP_W+1]=ALUSrc.
  - fIFIDa4, fBR1, fBR2, fSE  in  DATA_W each  PC+4, register read 1, register read 2, sign-extended immediate.
  - fIns1, fIns2  in  REG_W each  rt/rd specifiers.
  - jump_in  in  1  jump flag.
- Control inputs:
  - flush  in  1  synchronous squash of all held entries.
  - out_ready  in  1  execute accepts the presented entry.
- Execute-side outputs:
  - out_valid  out  1  main entry valid.
  - Wb1  out  WB_W  write-back control.
  - Mem1  out  M_W  memory control.
  - RegDst  out  1  unpacked from EX.
  - ALUOp  out  ALUOP_W  unpacked from EX.
  - ALUSrc  out  1  unpacked from EX.
  - tAdd, tALU, tMux32, tACsl  out  DATA_W each  registered datapath fields.
  - tMux5_1, tMux5_2  out  REG_W each  registered register specifiers.
  - jump_out  out  1  registered jump flag.
  - stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main entry drives the outputs; a skid entry holds one overflow entry. Each entry holds all fields.
- State machine, registered:
  - EMPTY: no valid entry.
  - FULL: main entry valid.
  - SKID: main and skid entries both valid.
- Handshake signals:
  - in_ready = (state != SKID); it is a pure decode of the state register.
  - out_valid = (state != EMPTY).
- Transitions, evaluated when flush=0 (acc = in_valid & in_ready):
  - EMPTY: acc -> FULL, load main; otherwise stay EMPTY.
  - FULL:
    - acc & out_ready -> FULL, main replaced by input.
    - acc & !out_ready -> SKID, input loaded into skid.
    - !acc & out_ready -> EMPTY.
    - Otherwise hold.
  - SKID: out_ready -> FULL, main <= skid. Otherwise hold. No input is accepted in SKID.
- Flush:
  - flush=1 forces the next state to EMPTY regardless of in_valid or out_ready. Any entry offered in that same cycle is discarded.
  - Datapath registers keep their values; control outputs read zero because they are gated (see below).
- Bubble gating: Wb1, Mem1, RegDst, ALUOp, ALUSrc and jump_out are ANDed with out_valid. An invalid stage therefore never issues a write-back, memory or jump action. Datapath outputs are not gated.
- EX unpacking is a field slice only; no re-encoding.
- stall_cnt:
  - Increments by 1 on each cycle where out_valid & !out_ready, including a cycle where flush=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.

## Timing
- Reset (rstIDEX_n=0, asynchronous assert):
  - State is EMPTY, so out_valid=0 and in_ready=1.
  - All data/control outputs and both entries are 0; stall_cnt=0.
  - Deassertion takes effect at the first clkIDEX edge after release.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N is on the outputs with out_valid=1 after edge N.
- Throughput: one entry per cycle while out_ready=1.
- Ordering: entries leave strictly in acceptance order; the skid entry always follows the main entry.
- Stalls:
  - One stall cycle with in_valid held high fills the skid entry.
  - In SKID, in_ready=0 until the cycle after out_ready=1 drains main.
- Outputs are stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - flush beats acceptance and draining.
  - In FULL with acc & out_ready, the pass-through happens in the same edge.

## Test plan
- Reset and pass-through: assert rstIDEX_n=0 mid-clock -> all outputs 0 immediately, in_ready=1. Release, then drive EX=5'b1_011_1, fBR1=32'hDEAD_BEEF with in_valid=1 and out_ready=1 -> next cycle out_valid=1, RegDst=1, ALUOp=3'b011, ALUSrc=1, tALU=32'hDEAD_BEEF.
- Back-to-back streaming: drive 8 entries tagged fSE=1..8 with out_ready=1 -> outputs tACsl=1..8 on consecutive cycles, no gaps.
- Skid stall: stream A, B, C; drop out_ready for 3 cycles after A is presented -> state reaches SKID with B in skid, in_ready=0, C held off. After out_ready=1, outputs are A, B, C in order. stall_cnt=3.
- Flush in SKID with in_valid=1: next cycle out_valid=0, Wb1=0, Mem1=0, jump_out=0, in_ready=1. The offered entry never appears on the outputs.
- Counter saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF. A subsequent flush leaves stall_cnt=4'hF.
- Jump bubble gating: accept jump_in=1, then flush the same cycle it is presented -> jump_out pulses for exactly one cycle and is 0 from then on.

Source files
------------

// File: rtl/idex_elastic_stage.sv
// ID/EX elastic pipeline stage: main + skid entry behind a valid/ready handshake,
// synchronous flush, bubble-gated control outputs and a saturating stall counter.
module idex_elastic_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int WB_W    = 2,
   parameter int M_W     = 3,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic                 clkIDEX,
   input  logic                 rstIDEX_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WB_W-1:0]      WB1,
   input  logic [M_W-1:0]       M1,
   input  logic [ALUOP_W+1:0]   EX,
   input  logic [DATA_W-1:0]    fIFIDa4,
   input  logic [DATA_W-1:0]    fBR1,
   input  logic [DATA_W-1:0]    fBR2,
   input  logic [DATA_W-1:0]    fSE,
   input  logic [REG_W-1:0]     fIns1,
   input  logic [REG_W-1:0]     fIns2,
   input  logic                 jump_in,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [WB_W-1:0]      Wb1,
   output logic [M_W-1:0]       Mem1,
   output logic                 RegDst,
   output logic [ALUOP_W-1:0]   ALUOp,
   output logic                 ALUSrc,
   output logic [DATA_W-1:0]    tAdd,
   output logic [DATA_W-1:0]    tALU,
   output logic [DATA_W-1:0]    tMux32,
   output logic [DATA_W-1:0]    tACsl,
   output logic [REG_W-1:0]     tMux5_1,
   output logic [REG_W-1:0]     tMux5_2,
   output logic                 jump_out,
   output logic [CNT_W-1:0]     stall_cnt
);

   typedef struct packed {
      logic [WB_W-1:0]     wb;
      logic [M_W-1:0]      m;
      logic [ALUOP_W+1:0]  ex;
      logic [DATA_W-1:0]   a4;
      logic [DATA_W-1:0]   br1;
      logic [DATA_W-1:0]   br2;
      logic [DATA_W-1:0]   se;
      logic [REG_W-1:0]    ins1;
      logic [REG_W-1:0]    ins2;
      logic                jump;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   state_t state, state_nxt;
   entry_t main_q, skid_q, in_e;
   logic   acc, load_main, load_skid, skid_to_main;

   assign in_e = '{wb: WB1, m: M1, ex: EX, a4: fIFIDa4, br1: fBR1, br2: fBR2,
                   se: fSE, ins1: fIns1, ins2: fIns2, jump: jump_in};

   assign in_ready  = (state != SKID);
   assign out_valid = (state != EMPTY);
   assign acc       = in_valid & in_ready;

   always_comb begin
      state_nxt    = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (acc) begin
               state_nxt = FULL;
               load_main = 1'b1;
            end
            FULL: begin
               if (acc && out_ready) begin
                  load_main = 1'b1;
               end else if (acc) begin
                  state_nxt = SKID;
                  load_skid = 1'b1;
               end else if (out_ready) begin
                  state_nxt = EMPTY;
               end
            end
            SKID: if (out_ready) begin
               state_nxt    = FULL;
               skid_to_main = 1'b1;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clkIDEX or negedge rstIDEX_n) begin
      if (!rstIDEX_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_main)         main_q <= in_e;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= in_e;
      end
   end

   // Counts every stalled presentation, flush cycles included; sticks at all-ones.
   always_ff @(posedge clkIDEX or negedge rstIDEX_n) begin
      if (!rstIDEX_n)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign Wb1      = main_q.wb & {WB_W{out_valid}};
   assign Mem1     = main_q.m  & {M_W{out_valid}};
   assign RegDst   = main_q.ex[0] & out_valid;
   assign ALUOp    = main_q.ex[ALUOP_W:1] & {ALUOP_W{out_valid}};
   assign ALUSrc   = main_q.ex[ALUOP_W+1] & out_valid;
   assign jump_out = main_q.jump & out_valid;

   assign tAdd    = main_q.a4;
   assign tALU    = main_q.br1;
   assign tMux32  = main_q.br2;
   assign tACsl   = main_q.se;
   assign tMux5_1 = main_q.ins1;
   assign tMux5_2 = main_q.ins2;

endmodule

// File: tb/tb_idex_elastic_stage.sv
// Directed + randomized bench for idex_elastic_stage against a queue-based reference model.
module tb_idex_elastic_stage;
   localparam int DATA_W = 32, REG_W = 5, WB_W = 2, M_W = 3, ALUOP_W = 3, CNT_W = 4;
   localparam int CMAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [WB_W-1:0]    wb;
      logic [M_W-1:0]     m;
      logic [ALUOP_W+1:0] ex;
      logic [DATA_W-1:0]  a4, br1, br2, se;
      logic [REG_W-1:0]   i1, i2;
      logic               j;
   } ent_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   ent_t din = '0;
   logic in_ready, out_valid, RegDst, ALUSrc, jump_out;
   logic [WB_W-1:0] Wb1;
   logic [M_W-1:0] Mem1;
   logic [ALUOP_W-1:0] ALUOp;
   logic [DATA_W-1:0] tAdd, tALU, tMux32, tACsl;
   logic [REG_W-1:0] tMux5_1, tMux5_2;
   logic [CNT_W-1:0] stall_cnt;

   int checks = 0, errors = 0;
   ent_t q[$];
   ent_t shown = '0;
   int cnt = 0;

   always #5 clk = ~clk;

   idex_elastic_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .M_W(M_W),
                        .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
      .clkIDEX(clk), .rstIDEX_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .WB1(din.wb), .M1(din.m), .EX(din.ex), .fIFIDa4(din.a4), .fBR1(din.br1),
      .fBR2(din.br2), .fSE(din.se), .fIns1(din.i1), .fIns2(din.i2), .jump_in(din.j),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .Wb1(Wb1),
      .Mem1(Mem1), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .tAdd(tAdd),
      .tALU(tALU), .tMux32(tMux32), .tACsl(tACsl), .tMux5_1(tMux5_1),
      .tMux5_2(tMux5_2), .jump_out(jump_out), .stall_cnt(stall_cnt));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.wb = WB_W'($urandom);  e.m = M_W'($urandom);  e.ex = (ALUOP_W+2)'($urandom);
      e.a4 = $urandom;  e.br1 = $urandom;  e.br2 = $urandom;  e.se = $urandom;
      e.i1 = REG_W'($urandom);  e.i2 = REG_W'($urandom);  e.j = 1'($urandom);
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      shown = '0;
      cnt = 0;
   endtask

   // Full comparison of every output against the model's view of the stage.
   task automatic compare_all();
      logic v;
      ent_t h;
      v = (q.size() != 0);
      h = v ? q[0] : '0;
      check("out_valid", 64'(out_valid), 64'(v));
      check("in_ready",  64'(in_ready), 64'(q.size() < 2));
      check("stall_cnt", 64'(stall_cnt), 64'(cnt));
      check("Wb1",       64'(Wb1), 64'(h.wb));
      check("Mem1",      64'(Mem1), 64'(h.m));
      check("RegDst",    64'(RegDst), 64'(h.ex[0]));
      check("ALUOp",     64'(ALUOp), 64'(h.ex[ALUOP_W:1]));
      check("ALUSrc",    64'(ALUSrc), 64'(h.ex[ALUOP_W+1]));
      check("jump_out",  64'(jump_out), 64'(h.j));
      check("tAdd",      64'(tAdd), 64'(shown.a4));
      check("tALU",      64'(tALU), 64'(shown.br1));
      check("tMux32",    64'(tMux32), 64'(shown.br2));
      check("tACsl",     64'(tACsl), 64'(shown.se));
      check("tMux5_1",   64'(tMux5_1), 64'(shown.i1));
      check("tMux5_2",   64'(tMux5_2), 64'(shown.i2));
   endtask

   // One clock: sample inputs, advance the model, compare #1 after the edge.
   task automatic cyc();
      logic iv, ordy, fl, ov, ir;
      ent_t d;
      iv = in_valid; ordy = out_ready; fl = flush; d = din;
      ov = (q.size() > 0); ir = (q.size() < 2);
      @(posedge clk);
      if (ov && !ordy && cnt < CMAX) cnt++;
      if (fl) q.delete();
      else begin
         if (ov && ordy) void'(q.pop_front());
         if (iv && ir) q.push_back(d);
      end
      if (q.size() != 0) shown = q[0];
      #1;
      compare_all();
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic fl, input ent_t e);
      in_valid = iv; out_ready = ordy; flush = fl; din = e;
   endtask

   initial begin
      ent_t e;
      int base;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk) rst_n = 1'b1;

      // Pass-through with explicit field values
      e = '0; e.ex = 5'b1_011_1; e.br1 = 32'hDEAD_BEEF;
      drive(1, 1, 0, e);
      cyc();
      check("pt_RegDst", 64'(RegDst), 64'd1);
      check("pt_ALUOp",  64'(ALUOp), 64'd3);
      check("pt_ALUSrc", 64'(ALUSrc), 64'd1);
      check("pt_tALU",   64'(tALU), 64'hDEAD_BEEF);

      // Back-to-back streaming
      for (int i = 1; i <= 8; i++) begin
         e = rand_ent(); e.se = i;
         drive(1, 1, 0, e);
         cyc();
         check("stream_tACsl", 64'(tACsl), 64'(i));
         check("stream_valid", 64'(out_valid), 64'd1);
      end
      drive(0, 1, 0, '0);
      cyc();

      // Skid stall: A, B, C with three stall cycles
      e = rand_ent(); e.se = 32'hA; drive(1, 1, 0, e); cyc();
      e = rand_ent(); e.se = 32'hB; drive(1, 0, 0, e); cyc();
      check("skid_in_ready", 64'(in_ready), 64'd0);
      e = rand_ent(); e.se = 32'hC; drive(1, 0, 0, e); cyc(); cyc();
      check("skid_hold_A", 64'(tACsl), 64'hA);
      check("skid_stall_cnt", 64'(stall_cnt), 64'd3);
      drive(1, 1, 0, e); cyc();
      check("skid_order_B", 64'(tACsl), 64'hB);
      cyc();
      check("skid_order_C", 64'(tACsl), 64'hC);
      drive(0, 1, 0, '0); cyc();
      check("skid_drained", 64'(out_valid), 64'd0);

      // Flush in SKID with a new entry offered
      drive(1, 1, 0, rand_ent()); cyc();
      drive(1, 0, 0, rand_ent()); cyc();
      e = rand_ent(); e.wb = '1; e.m = '1; e.j = 1'b1; e.se = 32'hD;
      drive(1, 0, 1, e); cyc();
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_wb", 64'(Wb1), 64'd0);
      check("flush_mem", 64'(Mem1), 64'd0);
      check("flush_jump", 64'(jump_out), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      drive(0, 1, 0, '0); cyc(); cyc();
      check("flush_discard", 64'(out_valid), 64'd0);

      // Counter saturation, then flush leaves it pinned
      drive(1, 0, 0, rand_ent()); cyc();
      drive(0, 0, 0, '0);
      repeat (20) cyc();
      check("sat_cnt", 64'(stall_cnt), 64'(CMAX));
      drive(0, 0, 1, '0); cyc();
      check("sat_after_flush", 64'(stall_cnt), 64'(CMAX));

      // Jump bubble gating: accept, then flush while presented
      e = rand_ent(); e.j = 1'b1;
      drive(1, 0, 0, e); cyc();
      check("jump_pulse", 64'(jump_out), 64'd1);
      drive(0, 0, 1, '0); cyc();
      check("jump_gone", 64'(jump_out), 64'd0);
      drive(0, 1, 0, '0); cyc();
      check("jump_stays_0", 64'(jump_out), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 15) == 0), rand_ent());
         cyc();
      end

      // Asynchronous reset mid-operation
      drive(1, 0, 0, rand_ent()); cyc(); cyc();
      base = checks;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("async_rst_checked", 64'(checks - base), 64'd15);
      drive(0, 1, 0, '0);
      @(negedge clk) rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 20) == 0), rand_ent());
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
